// File: rtl/bram_ctrl_pkg.sv
// Shared constants for the BRAM stream reader: FSM encoding, default geometry
// and the read-credit rule.
package bram_ctrl_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 256;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // credit = reads in flight + buffered words; the 2-entry buffer can always
   // absorb a new read below 2, or at 2 when a word leaves this cycle.
   function automatic logic credit_ok(input logic [2:0] credit, input logic pop);
      return (credit < 3'd2) || ((credit == 3'd2) && pop);
   endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO; a push into a full FIFO is accepted only when a
// pop happens in the same cycle.
module stream_fifo2 #(
   parameter int W = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   count
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= !wr_ptr;
         end
         if (do_pop)
            rd_ptr <= !rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Reads a burst of consecutive BRAM words (wrapping at DEPTH) and streams them
// out on an AXI-Stream master, throttled by a two-word read credit.
module bram_stream_reader
   import bram_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int ADDR  = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [ADDR-1:0]  cfg_base,
   input  logic [ADDR:0]    cfg_len,
   output logic             busy,
   output logic             done,
   output logic             bram_en,
   output logic [ADDR-1:0]  bram_addr,
   input  logic [WIDTH-1:0] bram_dout,
   input  logic             bram_valid,
   output logic [WIDTH-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tlast
);

   localparam logic [ADDR:0]   LEN_ONE  = 1;
   localparam logic [ADDR-1:0] ADDR_ONE = 1;

   logic [1:0]      state;
   logic [ADDR-1:0] addr;
   logic [ADDR:0]   len_q;
   logic [ADDR:0]   remaining;
   logic [ADDR:0]   pushed;
   logic [1:0]      inflight;
   logic            done_q;

   logic [WIDTH:0]  fifo_din;
   logic [WIDTH:0]  fifo_dout;
   logic            fifo_full;
   logic            fifo_empty;
   logic [1:0]      fifo_count;

   logic            issue;
   logic            push;
   logic            pop;
   logic [2:0]      credit;

   assign credit = {1'b0, inflight} + {1'b0, fifo_count};
   assign pop    = !fifo_empty && m_axis_tready;
   assign issue  = !rst && (state == ST_RUN) && (remaining != '0) && credit_ok(credit, pop);

   // A strobe with no read outstanding (stray, or left over from a reset) is dropped.
   assign push     = !rst && bram_valid && (inflight != 2'd0) && (!fifo_full || pop);
   assign fifo_din = {(pushed == len_q - LEN_ONE), bram_dout};

   stream_fifo2 #(
      .W (WIDTH + 1)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign busy          = (state != ST_IDLE);
   assign done          = done_q;
   assign bram_en       = issue;
   assign bram_addr     = addr;
   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tdata  = fifo_empty ? '0 : fifo_dout[WIDTH-1:0];
   assign m_axis_tlast  = !fifo_empty && fifo_dout[WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         len_q     <= '0;
         remaining <= '0;
         pushed    <= '0;
         inflight  <= 2'd0;
         done_q    <= 1'b0;
      end else begin
         // done is registered off the DONE state, so it trails DONE by a cycle
         done_q <= (state == ST_DONE);

         if (push)
            pushed <= pushed + LEN_ONE;

         case ({issue, push})
            2'b10:   inflight <= inflight + 2'd1;
            2'b01:   inflight <= inflight - 2'd1;
            default: inflight <= inflight;
         endcase

         if (issue) begin
            addr      <= addr + ADDR_ONE;
            remaining <= remaining - LEN_ONE;
         end

         case (state)
            ST_IDLE: begin
               if (cfg_start) begin
                  len_q     <= cfg_len;
                  remaining <= cfg_len;
                  addr      <= cfg_base;
                  pushed    <= '0;
                  state     <= (cfg_len != '0) ? ST_RUN : ST_DONE;
               end
            end
            ST_RUN: begin
               if (issue && (remaining == LEN_ONE))
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (pop && m_axis_tlast)
                  state <= ST_DONE;
            end
            ST_DONE:  state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model plus a stream monitor; each test
// compares captured traffic against words fetched directly from the model memory.
module tb_bram_stream_reader;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int ADDR  = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_start;
   logic [ADDR-1:0]  cfg_base;
   logic [ADDR:0]    cfg_len;
   logic             busy;
   logic             done;
   logic             bram_en;
   logic [ADDR-1:0]  bram_addr;
   logic [WIDTH-1:0] bram_dout;
   logic             bram_valid;
   logic [WIDTH-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             m_axis_tlast;

   always #5 clk = ~clk;

   bram_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg_start     (cfg_start),
      .cfg_base      (cfg_base),
      .cfg_len       (cfg_len),
      .busy          (busy),
      .done          (done),
      .bram_en       (bram_en),
      .bram_addr     (bram_addr),
      .bram_dout     (bram_dout),
      .bram_valid    (bram_valid),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   // BRAM model: one-cycle read latency; stray lets the bench inject bogus strobes
   logic [WIDTH-1:0] mem [DEPTH];
   logic             rd_q = 1'b0;
   logic             stray;
   always @(posedge clk) begin
      rd_q <= bram_en;
      if (bram_en) bram_dout <= mem[bram_addr];
   end
   assign bram_valid = rd_q | stray;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;

   logic [ADDR-1:0]  addr_q[$];
   logic [WIDTH-1:0] data_q[$];
   logic             last_q[$];
   int               hs_cyc_q[$];
   int               done_cyc_q[$];
   int first_en, first_tv, en_cnt, tv_cnt, issued, popped, credit_viol, stall_viol;
   logic             prev_stall;
   logic [WIDTH-1:0] prev_data;
   logic             prev_last;

   task automatic clear_mon();
      addr_q.delete(); data_q.delete(); last_q.delete();
      hs_cyc_q.delete(); done_cyc_q.delete();
      first_en = -1; first_tv = -1; en_cnt = 0; tv_cnt = 0;
      issued = 0; popped = 0; credit_viol = 0; stall_viol = 0;
      prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
   endtask

   always @(negedge clk) begin
      if (bram_en) begin
         addr_q.push_back(bram_addr);
         issued++; en_cnt++;
         if (first_en < 0) first_en = cyc;
      end
      if (m_axis_tvalid) begin
         tv_cnt++;
         if (first_tv < 0) first_tv = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
         data_q.push_back(m_axis_tdata);
         last_q.push_back(m_axis_tlast);
         hs_cyc_q.push_back(cyc);
         popped++;
      end
      if (done) done_cyc_q.push_back(cyc);
      if (!rst && (issued - popped > 2)) credit_viol++;
      if (!rst && prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data ||
                                 m_axis_tlast !== prev_last)) stall_viol++;
      prev_stall = !rst && m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic start_burst(input logic [ADDR-1:0] base, input logic [ADDR:0] len, output int k);
      step();
      cfg_base = base; cfg_len = len; cfg_start = 1'b1; k = cyc;
      step();
      cfg_start = 1'b0;
   endtask

   // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready
   task automatic wait_done(input int mode, input int limit, output logic to);
      int n = 0;
      to = 1'b0;
      while (done_cyc_q.size() == 0) begin
         if (n >= limit) begin to = 1'b1; break; end
         case (mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((n % 4) == 0) || ((n % 4) == 3);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         step(); n++;
      end
      m_axis_tready = 1'b1;
      repeat (2) step();
   endtask

   task automatic randomize_mem();
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      vectors++;
      if ({busy, done, bram_en, m_axis_tvalid, m_axis_tlast} !== 5'b0) begin
         miscompares++; $display("FAIL reset_flags: got %b, expected 00000",
                                 {busy, done, bram_en, m_axis_tvalid, m_axis_tlast});
      end
      vectors++;
      if (bram_addr !== '0) begin
         miscompares++; $display("FAIL reset_addr: got %0d, expected 0", bram_addr);
      end
      vectors++;
      if (m_axis_tdata !== '0) begin
         miscompares++; $display("FAIL reset_tdata: got %0h, expected 0", m_axis_tdata);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      int k; logic to;
      for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i + 100);
      clear_mon();
      start_burst('0, 4, k);
      vectors++;
      if (busy !== 1'b1) begin
         miscompares++; $display("FAIL basic_busy: got %b, expected 1", busy);
      end
      wait_done(0, 40, to);
      vectors++;
      if (to) begin miscompares++; $display("FAIL basic_timeout: got no done, expected done"); end
      vectors++;
      if (first_en !== k + 1) begin
         miscompares++; $display("FAIL basic_en_latency: got cycle %0d, expected %0d", first_en, k + 1);
      end
      vectors++;
      if (first_tv !== k + 3) begin
         miscompares++; $display("FAIL basic_tvalid_latency: got cycle %0d, expected %0d", first_tv, k + 3);
      end
      vectors++;
      if (data_q.size() !== 4) begin
         miscompares++; $display("FAIL basic_count: got %0d, expected 4", data_q.size());
      end
      for (int i = 0; i < 4 && i < data_q.size(); i++) begin
         vectors++;
         if (data_q[i] !== 32'(100 + i) || last_q[i] !== (i == 3)) begin
            miscompares++; $display("FAIL basic_word%0d: got %0d last %b, expected %0d last %b",
                                    i, data_q[i], last_q[i], 100 + i, i == 3);
         end
      end
      if (hs_cyc_q.size() == 4) begin
         vectors++;
         if (hs_cyc_q[3] - hs_cyc_q[0] !== 3) begin
            miscompares++; $display("FAIL basic_bubbles: got span %0d, expected 3", hs_cyc_q[3] - hs_cyc_q[0]);
         end
         vectors++;
         if (done_cyc_q.size() !== 1 || done_cyc_q[0] !== hs_cyc_q[3] + 2) begin
            miscompares++; $display("FAIL basic_done: got %0d pulses first %0d, expected 1 at %0d",
                                    done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] : -1, hs_cyc_q[3] + 2);
         end
      end
   endtask

   task automatic test_wrap();
      int k; logic to;
      randomize_mem(); clear_mon();
      start_burst(ADDR'(DEPTH - 2), 4, k);
      wait_done(0, 40, to);
      vectors++;
      if (to || addr_q.size() !== 4) begin
         miscompares++; $display("FAIL wrap_reads: got %0d reads, expected 4", addr_q.size());
      end
      for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
         vectors++;
         if (addr_q[i] !== ADDR'((DEPTH - 2 + i) % DEPTH)) begin
            miscompares++; $display("FAIL wrap_addr%0d: got %0d, expected %0d", i, addr_q[i], (DEPTH - 2 + i) % DEPTH);
         end
      end
      for (int i = 0; i < 4 && i < data_q.size(); i++) begin
         vectors++;
         if (data_q[i] !== mem[(DEPTH - 2 + i) % DEPTH]) begin
            miscompares++; $display("FAIL wrap_word%0d: got %0h, expected %0h", i, data_q[i], mem[(DEPTH - 2 + i) % DEPTH]);
         end
      end
   endtask

   task automatic test_stall();
      int k; logic to; logic [ADDR-1:0] base;
      randomize_mem(); clear_mon();
      base = ADDR'($urandom_range(0, DEPTH - 1));
      start_burst(base, 8, k);
      wait_done(1, 120, to);
      vectors++;
      if (to || data_q.size() !== 8) begin
         miscompares++; $display("FAIL stall_count: got %0d words, expected 8", data_q.size());
      end
      for (int i = 0; i < 8 && i < data_q.size(); i++) begin
         vectors++;
         if (data_q[i] !== mem[(int'(base) + i) % DEPTH] || last_q[i] !== (i == 7)) begin
            miscompares++; $display("FAIL stall_word%0d: got %0h last %b, expected %0h last %b",
                                    i, data_q[i], last_q[i], mem[(int'(base) + i) % DEPTH], i == 7);
         end
      end
      vectors++;
      if (stall_viol !== 0) begin miscompares++; $display("FAIL stall_stable: got %0d changes, expected 0", stall_viol); end
      vectors++;
      if (credit_viol !== 0) begin miscompares++; $display("FAIL stall_credit: got %0d overruns, expected 0", credit_viol); end
   endtask

   task automatic test_zero();
      int k; logic to;
      clear_mon();
      start_burst(ADDR'(5), 0, k);
      wait_done(0, 20, to);
      vectors++;
      if (to || done_cyc_q.size() !== 1 || done_cyc_q[0] !== k + 2) begin
         miscompares++; $display("FAIL zero_done: got %0d pulses first %0d, expected 1 at %0d",
                                 done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] : -1, k + 2);
      end
      vectors++;
      if (en_cnt !== 0 || tv_cnt !== 0) begin
         miscompares++; $display("FAIL zero_quiet: got en %0d tvalid %0d, expected 0 0", en_cnt, tv_cnt);
      end
   endtask

   task automatic test_full_depth();
      int k; logic to; logic [ADDR-1:0] base;
      randomize_mem(); clear_mon();
      base = ADDR'($urandom_range(0, DEPTH - 1));
      start_burst(base, (ADDR+1)'(DEPTH), k);
      wait_done(2, 400, to);
      vectors++;
      if (to || addr_q.size() !== DEPTH || data_q.size() !== DEPTH) begin
         miscompares++; $display("FAIL full_count: got %0d reads %0d words, expected %0d",
                                 addr_q.size(), data_q.size(), DEPTH);
      end
      for (int i = 0; i < DEPTH && i < data_q.size() && i < addr_q.size(); i++) begin
         vectors++;
         if (addr_q[i] !== ADDR'((int'(base) + i) % DEPTH) || data_q[i] !== mem[(int'(base) + i) % DEPTH]) begin
            miscompares++; $display("FAIL full_word%0d: got addr %0d data %0h, expected addr %0d data %0h",
                                    i, addr_q[i], data_q[i], (int'(base) + i) % DEPTH, mem[(int'(base) + i) % DEPTH]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int k; logic to;
      randomize_mem(); clear_mon();
      start_burst(ADDR'(2), 6, k);
      step();
      cfg_base = ADDR'(9); cfg_len = 3; cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      wait_done(0, 60, to);
      vectors++;
      if (to || data_q.size() !== 6 || done_cyc_q.size() !== 1) begin
         miscompares++; $display("FAIL ignore_len: got %0d words %0d done, expected 6 words 1 done",
                                 data_q.size(), done_cyc_q.size());
      end
      for (int i = 0; i < 6 && i < data_q.size(); i++) begin
         vectors++;
         if (data_q[i] !== mem[2 + i]) begin
            miscompares++; $display("FAIL ignore_word%0d: got %0h, expected %0h", i, data_q[i], mem[2 + i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int k; int n; logic to;
      randomize_mem(); clear_mon();
      start_burst('0, 10, k);
      n = 0;
      while (popped < 3 && n < 40) begin step(); n++; end
      vectors++;
      if (popped < 3) begin miscompares++; $display("FAIL midrst_wait: got %0d handshakes, expected 3", popped); end
      rst = 1'b1;
      step();
      vectors++;
      if ({busy, done, bram_en, m_axis_tvalid, m_axis_tlast} !== 5'b0 || bram_addr !== '0 || m_axis_tdata !== '0) begin
         miscompares++; $display("FAIL midrst_outputs: got flags %b addr %0d data %0h, expected all 0",
                                 {busy, done, bram_en, m_axis_tvalid, m_axis_tlast}, bram_addr, m_axis_tdata);
      end
      rst = 1'b0;
      clear_mon();
      stray = 1'b1;
      step();
      stray = 1'b0;
      repeat (12) step();
      vectors++;
      if (done_cyc_q.size() !== 0 || tv_cnt !== 0) begin
         miscompares++; $display("FAIL midrst_quiet: got done %0d tvalid %0d, expected 0 0", done_cyc_q.size(), tv_cnt);
      end
      clear_mon();
      start_burst(ADDR'(7), 2, k);
      wait_done(0, 30, to);
      vectors++;
      if (to || data_q.size() !== 2) begin
         miscompares++; $display("FAIL midrst_next_count: got %0d words, expected 2", data_q.size());
      end
      for (int i = 0; i < 2 && i < data_q.size(); i++) begin
         vectors++;
         if (data_q[i] !== mem[7 + i] || last_q[i] !== (i == 1)) begin
            miscompares++; $display("FAIL midrst_next_word%0d: got %0h last %b, expected %0h last %b",
                                    i, data_q[i], last_q[i], mem[7 + i], i == 1);
         end
      end
   endtask

   task automatic test_random();
      int k; logic to; logic [ADDR-1:0] base; int len;
      for (int b = 0; b < 6; b++) begin
         randomize_mem(); clear_mon();
         base = ADDR'($urandom_range(0, DEPTH - 1));
         len  = $urandom_range(1, DEPTH);
         start_burst(base, (ADDR+1)'(len), k);
         wait_done(2, 400, to);
         vectors++;
         if (to || data_q.size() !== len || stall_viol !== 0 || credit_viol !== 0) begin
            miscompares++; $display("FAIL rand%0d_summary: got %0d words stall %0d credit %0d, expected %0d 0 0",
                                    b, data_q.size(), stall_viol, credit_viol, len);
         end
         for (int i = 0; i < len && i < data_q.size(); i++) begin
            vectors++;
            if (data_q[i] !== mem[(int'(base) + i) % DEPTH] || last_q[i] !== (i == len - 1)) begin
               miscompares++; $display("FAIL rand%0d_word%0d: got %0h last %b, expected %0h last %b",
                                       b, i, data_q[i], last_q[i], mem[(int'(base) + i) % DEPTH], i == len - 1);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_len = '0;
      m_axis_tready = 1'b1; stray = 1'b0;
      clear_mon();
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_zero();
      test_full_depth();
      test_ignore_start();
      test_mid_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
